// File: rtl/palette_mixer_if.sv
// rtl/palette_mixer_if.sv - CPU palette/control bus bundle for palette_mixer
interface palette_mixer_if;
    logic        PCS;
    logic        NRD;
    logic [12:1] AB;
    logic [7:0]  DB_IN;
    logic [7:0]  DB_OUT;
    logic        DB_DIR;
    logic        DTAC;

    modport master (
        output PCS, NRD, AB, DB_IN,
        input  DB_OUT, DB_DIR, DTAC
    );

    modport slave (
        input  PCS, NRD, AB, DB_IN,
        output DB_OUT, DB_DIR, DTAC
    );
endinterface

// File: rtl/palette_mixer.sv
// rtl/palette_mixer.sv - three-layer priority mixer with a CPU-shared 1024x16 palette
module palette_mixer (
    input  logic           clk_24M,
    input  logic           nRES,
    input  logic           ce_6M,
    input  logic [11:0]    VA,
    input  logic [11:0]    VB,
    input  logic [7:0]     FX,
    input  logic           NCBLK,
    palette_mixer_if.slave cpu,
    output logic [4:0]     R,
    output logic [4:0]     G,
    output logic [4:0]     B
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } cpu_state_t;

    logic [7:0] pal_hi [1024];
    logic [7:0] pal_lo [1024];

    logic [7:0] ctrl;
    cpu_state_t state, state_nxt;
    logic       cpu_go;

    logic       a_op, b_op, f_op;
    logic [9:0] idx_a, idx_b, idx_f, win_idx;

    logic [9:0] s1_idx;
    logic       s1_ncblk;

    logic [9:0] rd_addr;
    logic [7:0] hi_q, lo_q;
    logic [7:0] cpu_rd_byte;

    logic       unused_bits;
    assign unused_bits = ^{VA[11:8], VB[11:8], hi_q[7]};

    // Layer selection: a layer with pen 0 is see-through
    assign a_op  = (VA[3:0] != 4'd0);
    assign b_op  = (VB[3:0] != 4'd0);
    assign f_op  = (FX[3:0] != 4'd0);
    assign idx_a = {ctrl[3:2], VA[7:0]};
    assign idx_b = {ctrl[5:4], VB[7:0]};
    assign idx_f = {ctrl[7:6], FX};

    always_comb begin
        win_idx = 10'h000;
        case (ctrl[1:0])
            2'd0: begin
                if (f_op)      win_idx = idx_f;
                else if (a_op) win_idx = idx_a;
                else if (b_op) win_idx = idx_b;
            end
            2'd1: begin
                if (f_op)      win_idx = idx_f;
                else if (b_op) win_idx = idx_b;
                else if (a_op) win_idx = idx_a;
            end
            2'd2: begin
                if (a_op)      win_idx = idx_a;
                else if (f_op) win_idx = idx_f;
                else if (b_op) win_idx = idx_b;
            end
            2'd3: begin
                if (b_op)      win_idx = idx_b;
                else if (f_op) win_idx = idx_f;
                else if (a_op) win_idx = idx_a;
            end
        endcase
    end

    // One shared read port: video owns ce_6M cycles, the CPU owns the rest
    assign rd_addr = ce_6M ? s1_idx : cpu.AB[11:2];
    assign hi_q    = pal_hi[rd_addr];
    assign lo_q    = pal_lo[rd_addr];

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            s1_idx   <= 10'h000;
            s1_ncblk <= 1'b0;
            R        <= 5'd0;
            G        <= 5'd0;
            B        <= 5'd0;
        end else if (ce_6M) begin
            s1_idx   <= win_idx;
            s1_ncblk <= NCBLK;
            if (s1_ncblk) begin
                R <= lo_q[4:0];
                G <= {hi_q[1:0], lo_q[7:5]};
                B <= hi_q[6:2];
            end else begin
                R <= 5'd0;
                G <= 5'd0;
                B <= 5'd0;
            end
        end
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cpu_go     = 1'b0;
        cpu.DTAC   = 1'b1;
        cpu.DB_DIR = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cpu.PCS) state_nxt = S_IDLE == S_IDLE ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                // A select that goes away before the CPU slot is a silent abort
                if (cpu.PCS) begin
                    state_nxt = S_IDLE;
                end else if (!ce_6M) begin
                    cpu_go    = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                cpu.DTAC   = 1'b0;
                cpu.DB_DIR = cpu.NRD;
                if (cpu.PCS) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cpu_rd_byte = cpu.AB[12] ? ctrl : (cpu.AB[1] ? lo_q : hi_q);

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            ctrl       <= 8'h00;
            cpu.DB_OUT <= 8'h00;
        end else if (cpu_go) begin
            if (cpu.NRD)        cpu.DB_OUT <= cpu_rd_byte;
            else if (cpu.AB[12]) ctrl      <= cpu.DB_IN;
        end
    end

    // Palette contents survive reset; cpu_go is held low while nRES is low
    always_ff @(posedge clk_24M) begin
        if (cpu_go && !cpu.NRD && !cpu.AB[12]) begin
            if (cpu.AB[1]) pal_lo[cpu.AB[11:2]] <= cpu.DB_IN;
            else           pal_hi[cpu.AB[11:2]] <= cpu.DB_IN;
        end
    end
endmodule

// File: doc/palette_mixer.md
PALETTE_MIXER -- requirements
Module: palette_mixer

Interface
REQ-001 clk_24M  input  1  sole clock; all state changes on rising edge.
REQ-002 nRES  input  1  asynchronous active-low reset.
REQ-003 ce_6M  input  1  pixel enable, one clk_24M cycle high in every four.
REQ-004 VA  input  12  layer A pixel code; only [7:0] used, pen = [3:0].
REQ-005 VB  input  12  layer B pixel code; only [7:0] used, pen = [3:0].
REQ-006 FX  input  8  fix layer pixel code, pen = [3:0].
REQ-007 NCBLK  input  1  composite blank, active low.
REQ-008 PCS  input  1  CPU chip select, active low.
REQ-009 NRD  input  1  CPU direction: 1 = read, 0 = write.
REQ-010 AB  input  12 ([12:1])  CPU address; AB[12] = 1 selects CTRL, AB[12] = 0 selects palette byte AB[11:1].
REQ-011 DB_IN  input  8  CPU write data.
REQ-012 DB_OUT  output  8  CPU read data.
REQ-013 DB_DIR  output  1  1 while the block drives the CPU bus (read acknowledged).
REQ-014 DTAC  output  1  CPU data acknowledge, active low.
REQ-015 R, G, B  output  5 each  registered colour out.

Function
REQ-016 Palette SHALL be 1024 x 16 bits, stored as two 1024 x 8 arrays (high/low byte). AB[1] = 0 selects the high byte; AB[11:2] selects the entry.
REQ-017 Entry format SHALL be R = [4:0], G = [9:5], B = [14:10], with bit 15 ignored.
REQ-018 CTRL (8 bits) SHALL be laid out as: [1:0] priority mode, [3:2] bank A, [5:4] bank B, [7:6] bank FX.
REQ-019 Priority SHALL be, front to back: mode 0 FX>A>B, mode 1 FX>B>A, mode 2 A>FX>B, mode 3 B>FX>A.
REQ-020 A layer SHALL be transparent when its pen = 0; the winner is the highest-priority opaque layer.
REQ-021 Palette index SHALL be {bank of winner, code[7:0]}; if all layers are transparent, the index SHALL be 10'h000.
REQ-022 Stage 1, on ce_6M: register the winner index and NCBLK.
REQ-023 Stage 2, on the next ce_6M: read the palette at the stage-1 index and register R/G/B. The output is 0 if the delayed NCBLK = 0.
REQ-024 Latency SHALL be 2 ce_6M pulses from input sample to R/G/B update; R/G/B SHALL hold between pulses.
REQ-025 Video reads SHALL use only ce_6M cycles; CPU palette accesses SHALL use only cycles where ce_6M = 0.
REQ-026 CPU FSM states: IDLE, WAIT, ACK.
  - IDLE -> WAIT on PCS = 0.
  - WAIT -> ACK on the first cycle with ce_6M = 0; the access is performed in that cycle (write, or read latched into DB_OUT).
  - ACK: DTAC = 0, and DB_DIR = NRD; ACK -> IDLE when PCS = 1, at which point DTAC = 1 and DB_DIR = 0.
REQ-027 CTRL accesses SHALL follow the same FSM; a read returns CTRL.
REQ-028 If PCS rises while in WAIT, the FSM SHALL return to IDLE with no write and no acknowledge.
REQ-029 A CPU write to the entry being displayed SHALL be visible to the next ce_6M read; there is no collision because the slots are disjoint.
REQ-030 Bank fields concatenate without arithmetic; no wrap or carry is possible.

Reset
REQ-031 While nRES = 0, outputs SHALL be:
  - R = G = B = 0
  - DTAC = 1
  - DB_DIR = 0
  - DB_OUT = 8'h00
REQ-032 While nRES = 0, internal state SHALL be: CTRL = 8'h00, FSM = IDLE, pipeline index = 0, delayed NCBLK = 0.
REQ-033 Reset asserted mid-access SHALL abort the access; a write not yet performed SHALL NOT occur.
REQ-034 Palette contents SHALL NOT be reset.

Verification
REQ-035 Palette write: write 8'h7C to AB = 12'h002 and 8'h1F to AB = 12'h003 -> each access gets DTAC = 0 within 2 clk after PCS falls; readback returns the same bytes.
REQ-036 Priority: CTRL = 8'h00, VA = 8'h15, VB = 8'h22, FX = 8'h00, entry 0x015 = 16'h7C1F -> after 2 ce_6M pulses, R = 31, G = 0, B = 31.
REQ-037 Mode swap: CTRL = 8'h03, VA = 8'h15, VB = 8'h22, FX = 8'h31 -> index 0x022 is displayed; with all pens 0 -> index 0x000.
REQ-038 Blank: NCBLK = 0 with opaque pixels -> R = G = B = 0 exactly 2 ce_6M pulses later.
REQ-039 Abort and reset: PCS pulse of 1 cycle coinciding with ce_6M = 1 -> no DTAC and no write; nRES pulsed while in ACK -> DTAC = 1 immediately and CTRL = 0.
